// File: rtl/top_level_pkg.sv
// Shared types and constants for the Sobel edge-detection bus master.
// Holds the FSM state type, datapath widths, default frame geometry and the gray helper.
package top_level_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int PIX_W      = 8;
   localparam int GRAY_SUM_W = 10;
   localparam int SOBEL_W    = 12;

   localparam int DEF_WIDTH    = 428;
   localparam int DEF_HEIGHT   = 428;
   localparam int DEF_OUT_BASE = DEF_WIDTH * DEF_HEIGHT + 46;

   // The green byte is weighted double, so the sum needs two guard bits before the divide by 4.
   function automatic logic [PIX_W-1:0] rgb_to_gray(input logic [23:0] rgb);
      logic [GRAY_SUM_W-1:0] sum;
      sum = GRAY_SUM_W'(rgb[23:16]) + GRAY_SUM_W'({rgb[15:8], 1'b0}) + GRAY_SUM_W'(rgb[7:0]);
      return sum[GRAY_SUM_W-1:2];
   endfunction

endpackage

// File: rtl/top_level_sobel3x3.sv
// Combinational 3x3 Sobel magnitude: |Gx| + |Gy| saturated to 8 bits.
// Inputs are named pRC, where R is the window row (0 = top) and C is the column (0 = left).
module sobel3x3
   import top_level_pkg::*;
(
   input  logic [PIX_W-1:0] p00,
   input  logic [PIX_W-1:0] p01,
   input  logic [PIX_W-1:0] p02,
   input  logic [PIX_W-1:0] p10,
   input  logic [PIX_W-1:0] p11,
   input  logic [PIX_W-1:0] p12,
   input  logic [PIX_W-1:0] p20,
   input  logic [PIX_W-1:0] p21,
   input  logic [PIX_W-1:0] p22,
   output logic [PIX_W-1:0] mag
);

   logic signed [SOBEL_W-1:0] gx;
   logic signed [SOBEL_W-1:0] gy;
   logic signed [SOBEL_W-1:0] ax;
   logic signed [SOBEL_W-1:0] ay;
   logic signed [SOBEL_W-1:0] sum;
   logic                      unused_center;

   function automatic logic signed [SOBEL_W-1:0] ext(input logic [PIX_W-1:0] v);
      return signed'(SOBEL_W'(v));
   endfunction

   assign unused_center = ^p11;

   // Worst case |Gx| + |Gy| is 2040, which still fits the 12-bit signed range.
   always_comb begin
      gx  = (ext(p02) + (ext(p12) <<< 1) + ext(p22)) - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
      gy  = (ext(p20) + (ext(p21) <<< 1) + ext(p22)) - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
      ax  = (gx < 0) ? -gx : gx;
      ay  = (gy < 0) ? -gy : gy;
      sum = ax + ay;
      mag = (sum[SOBEL_W-1:PIX_W] != '0) ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
   end

endmodule

// File: rtl/top_level.sv
// Frame-level Sobel engine: fetches RGB pixels over a ready-handshake bus, converts them to
// gray, slides a 3x3 window over two line buffers and writes each interior magnitude back.
module top_level
   import top_level_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_WIDTH,
   parameter int IMG_HEIGHT = DEF_HEIGHT,
   parameter int OUT_BASE   = IMG_WIDTH * IMG_HEIGHT + 46
)(
   input  logic        clk,
   input  logic        n_rst,
   input  logic [31:0] hrdata,
   input  logic        hready,
   input  logic        stop,
   output logic [31:0] haddr,
   output logic [31:0] hwdata,
   output logic        hwrite,
   output logic        done
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
   localparam logic [31:0]   PIX_END   = 32'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [31:0]   WR_OFFSET = 32'(OUT_BASE - IMG_WIDTH - 1);

   state_t            state;
   logic [31:0]       haddr_r;
   logic [31:0]       pix_addr;
   logic [31:0]       wr_addr;
   logic              hwrite_r;
   logic              done_r;
   logic              pend_wr;
   logic [XW-1:0]     x_cnt;
   logic [YW-1:0]     y_cnt;

   logic [PIX_W-1:0]  lb_old [IMG_WIDTH];
   logic [PIX_W-1:0]  lb_new [IMG_WIDTH];
   logic [PIX_W-1:0]  win [3][3];
   logic [PIX_W-1:0]  gray;
   logic [PIX_W-1:0]  mag;
   logic              rd_done;
   logic              win_full;
   logic              unused_hrdata_hi;

   assign unused_hrdata_hi = ^hrdata[31:24];
   assign gray             = rgb_to_gray(hrdata[23:0]);
   assign rd_done          = (state == READ) && hready;
   assign win_full         = (x_cnt >= XW'(2)) && (y_cnt >= YW'(2));

   // Pixel (0,0) is never fetched; its column slot is seeded from pixel (1,0) on the first read.
   always_ff @(posedge clk) begin
      if (rd_done) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2]     <= lb_old[x_cnt];
         win[1][2]     <= lb_new[x_cnt];
         win[2][2]     <= gray;
         lb_old[x_cnt] <= lb_new[x_cnt];
         lb_new[x_cnt] <= gray;
         if (pix_addr == 32'd1) begin
            lb_new[0] <= gray;
         end
      end
   end

   sobel3x3 u_sobel (
      .p00 (win[0][0]),
      .p01 (win[0][1]),
      .p02 (win[0][2]),
      .p10 (win[1][0]),
      .p11 (win[1][1]),
      .p12 (win[1][2]),
      .p20 (win[2][0]),
      .p21 (win[2][1]),
      .p22 (win[2][2]),
      .mag (mag)
   );

   // The output address is the just-read pixel address shifted by a constant, so no second counter is needed.
   // A pause taken between a read and its write parks in IDLE with pend_wr set.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state    <= IDLE;
         haddr_r  <= '0;
         hwrite_r <= 1'b0;
         done_r   <= 1'b0;
         pend_wr  <= 1'b0;
         pix_addr <= 32'd1;
         wr_addr  <= '0;
         x_cnt    <= XW'(1);
         y_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!stop) begin
                  if (pend_wr) begin
                     state    <= WRITE;
                     haddr_r  <= wr_addr;
                     hwrite_r <= 1'b1;
                     pend_wr  <= 1'b0;
                  end else begin
                     state    <= READ;
                     haddr_r  <= pix_addr;
                     hwrite_r <= 1'b0;
                  end
               end
            end
            READ: begin
               if (hready) begin
                  pix_addr <= pix_addr + 32'd1;
                  if (x_cnt == X_LAST) begin
                     x_cnt <= '0;
                     y_cnt <= y_cnt + 1'b1;
                  end else begin
                     x_cnt <= x_cnt + 1'b1;
                  end
                  if (win_full) begin
                     wr_addr <= pix_addr + WR_OFFSET;
                     if (stop) begin
                        state   <= IDLE;
                        haddr_r <= '0;
                        pend_wr <= 1'b1;
                     end else begin
                        state    <= WRITE;
                        haddr_r  <= pix_addr + WR_OFFSET;
                        hwrite_r <= 1'b1;
                     end
                  end else if (stop) begin
                     state   <= IDLE;
                     haddr_r <= '0;
                  end else begin
                     haddr_r <= pix_addr + 32'd1;
                  end
               end
            end
            WRITE: begin
               if (hready) begin
                  hwrite_r <= 1'b0;
                  if (pix_addr == PIX_END) begin
                     state   <= DONE;
                     haddr_r <= '0;
                     done_r  <= 1'b1;
                  end else if (stop) begin
                     state   <= IDLE;
                     haddr_r <= '0;
                  end else begin
                     state   <= READ;
                     haddr_r <= pix_addr;
                  end
               end
            end
            DONE: begin
               haddr_r <= '0;
            end
         endcase
      end
   end

   assign haddr  = haddr_r;
   assign hwrite = hwrite_r;
   assign done   = done_r;
   assign hwdata = (state == WRITE) ? {8'h00, mag, mag, mag} : 32'h0;

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level on an 8x8 frame: a memory slave with programmable wait states, a
// frame-level gray/Sobel model that predicts every bus transfer, and directed scenarios.
module tb_top_level;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int OB = 110;

   logic        tb_clk = 1'b0;
   logic        n_rst;
   logic        stop;
   logic        hready;
   logic [31:0] hrdata;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hwrite;
   logic        done;

   always #5 tb_clk = ~tb_clk;

   top_level #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .OUT_BASE(OB)) dut (
      .clk    (tb_clk),
      .n_rst  (n_rst),
      .hrdata (hrdata),
      .hready (hready),
      .stop   (stop),
      .haddr  (haddr),
      .hwdata (hwdata),
      .hwrite (hwrite),
      .done   (done)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } xfer_t;

   xfer_t       exp_q [$];
   xfer_t       exp_e;
   logic [31:0] mem [0:255];
   int          gray_m [0:H-1][0:W-1];
   int          out_m  [0:H-1][0:W-1];
   int          tests_run    = 0;
   int          tests_failed = 0;
   int          wait_states  = 0;
   int          wait_cnt     = 0;
   int          write_count  = 0;
   logic        pend         = 1'b0;
   logic [31:0] held_addr, held_data, last_addr;
   logic        held_wr;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic rst, input logic stp);
      @(posedge tb_clk);
      #2;
      n_rst = rst;
      stop  = stp;
   endtask

   function automatic int model_gray(input logic [31:0] px);
      return (int'(px[23:16]) + 2 * int'(px[15:8]) + int'(px[7:0])) / 4;
   endfunction

   function automatic logic [31:0] pixel_value(input int kind, input int x, input int y);
      case (kind)
         0:       return 32'h00808080;
         1:       return (x < 4) ? 32'h00000000 : 32'h00FFFFFF;
         default: return {8'hA5, 8'(x * 37 + y * 11), 8'(x * x * 5 + y * 3 + 1), 8'((y * 29) ^ (x * 7))};
      endcase
   endfunction

   // Builds the image in memory, the expected output frame and the expected bus transfer order.
   task automatic build_model(input int kind);
      int gx, gy, m;
      exp_q.delete();
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            mem[y * W + x] = pixel_value(kind, x, y);
            gray_m[y][x]   = model_gray(mem[y * W + x]);
            mem[OB + y * W + x] = 32'hDEADBEEF;
         end
      end
      gray_m[0][0] = gray_m[0][1];
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            out_m[y][x] = 0;
            if (x > 0 && y > 0 && x < W - 1 && y < H - 1) begin
               gx = (gray_m[y-1][x+1] + 2 * gray_m[y][x+1] + gray_m[y+1][x+1])
                  - (gray_m[y-1][x-1] + 2 * gray_m[y][x-1] + gray_m[y+1][x-1]);
               gy = (gray_m[y+1][x-1] + 2 * gray_m[y+1][x] + gray_m[y+1][x+1])
                  - (gray_m[y-1][x-1] + 2 * gray_m[y-1][x] + gray_m[y-1][x+1]);
               if (gx < 0) gx = -gx;
               if (gy < 0) gy = -gy;
               m = gx + gy;
               out_m[y][x] = (m > 255) ? 255 : m;
            end
         end
      end
      for (int a = 1; a < W * H; a++) begin
         exp_q.push_back('{addr: 32'(a), wr: 1'b0, data: 32'h0});
         if ((a % W) >= 2 && (a / W) >= 2) begin
            m = out_m[a / W - 1][a % W - 1];
            exp_q.push_back('{addr: 32'(OB + (a / W - 1) * W + (a % W - 1)), wr: 1'b1,
                              data: {8'h00, 8'(m), 8'(m), 8'(m)}});
         end
      end
   endtask

   task automatic complete_transfer();
      if (hwrite) begin
         mem[haddr[7:0]] = hwdata;
         write_count++;
         check_output("done_early", 32'(done), 32'd0);
      end else begin
         hrdata = mem[haddr[7:0]];
      end
      if (exp_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL unexpected_xfer: got addr %h, expected no transfer", haddr);
      end else begin
         exp_e = exp_q.pop_front();
         check_output("xfer_addr", haddr, exp_e.addr);
         check_output("xfer_hwrite", 32'(hwrite), 32'(exp_e.wr));
         if (exp_e.wr) check_output("xfer_hwdata", hwdata, exp_e.data);
      end
   endtask

   // Slave and compare process: decides hready for the coming edge and checks each transfer.
   always @(negedge tb_clk) begin
      if (n_rst) begin
         hready    = 1'b0;
         wait_cnt  = 0;
         pend      = 1'b0;
         last_addr = '0;
      end else begin
         if (pend) begin
            check_output("hold_haddr", haddr, held_addr);
            check_output("hold_hwrite", 32'(hwrite), 32'(held_wr));
            check_output("hold_hwdata", hwdata, held_data);
         end
         if (last_addr != 0 && haddr != 0) begin
            tests_run++;
            if (haddr == last_addr) begin
               tests_failed++;
               $display("[TB] FAIL repeat_addr: got %h again, expected a new address", haddr);
            end
         end
         last_addr = '0;
         pend      = 1'b0;
         if (haddr != 0) begin
            if (wait_cnt >= wait_states + 1) begin
               hready    = 1'b1;
               wait_cnt  = 0;
               last_addr = haddr;
               complete_transfer();
            end else begin
               hready    = 1'b0;
               wait_cnt++;
               pend      = 1'b1;
               held_addr = haddr;
               held_wr   = hwrite;
               held_data = hwdata;
            end
         end else begin
            hready   = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   task automatic run_frame(input int kind, input int ws, input int stop_at, input int abort_at);
      int cyc;
      wait_states = ws;
      write_count = 0;
      build_model(kind);
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      @(negedge tb_clk);
      check_output("reset_haddr", haddr, 32'h0);
      check_output("reset_hwrite", 32'(hwrite), 32'h0);
      check_output("reset_hwdata", hwdata, 32'h0);
      check_output("reset_done", 32'(done), 32'h0);
      apply_stimulus(1'b0, 1'b0);
      if (abort_at > 0) begin
         repeat (abort_at) @(negedge tb_clk);
         apply_stimulus(1'b1, 1'b0);
         @(posedge tb_clk);
         @(negedge tb_clk);
         check_output("abort_haddr", haddr, 32'h0);
         check_output("abort_hwrite", 32'(hwrite), 32'h0);
         check_output("abort_hwdata", hwdata, 32'h0);
         check_output("abort_done", 32'(done), 32'h0);
         write_count = 0;
         build_model(kind);
         apply_stimulus(1'b0, 1'b0);
      end
      cyc = 0;
      while (!done && cyc < 4000) begin
         @(negedge tb_clk);
         cyc++;
         if (stop_at > 0 && cyc == stop_at) begin
            apply_stimulus(1'b0, 1'b1);
            for (int i = 0; i < 10; i++) begin
               @(negedge tb_clk);
               if (i >= 3) check_output("stop_idle", haddr, 32'h0);
            end
            apply_stimulus(1'b0, 1'b0);
         end
      end
      check_output("done_seen", 32'(done), 32'd1);
      repeat (3) @(negedge tb_clk);
      check_output("done_sticky", 32'(done), 32'd1);
      check_output("done_haddr", haddr, 32'h0);
      check_output("write_count", 32'(write_count), 32'd36);
      check_output("queue_drained", 32'(exp_q.size()), 32'd0);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (x > 0 && y > 0 && x < W - 1 && y < H - 1)
               check_output("out_pixel", mem[OB + y * W + x],
                            {8'h00, 8'(out_m[y][x]), 8'(out_m[y][x]), 8'(out_m[y][x])});
            else
               check_output("out_border", mem[OB + y * W + x], 32'hDEADBEEF);
         end
      end
   endtask

   initial begin
      n_rst  = 1'b1;
      stop   = 1'b0;
      hready = 1'b0;
      hrdata = 32'h0;

      check_output("model_gray_mid", 32'(model_gray(32'h00808080)), 32'd128);
      check_output("model_gray_mix", 32'(model_gray(32'h00102030)), 32'd32);
      build_model(1);
      check_output("model_step_x2", 32'(out_m[1][2]), 32'd0);
      check_output("model_step_x3", 32'(out_m[1][3]), 32'd255);
      check_output("model_step_x4", 32'(out_m[4][4]), 32'd255);
      check_output("model_step_x5", 32'(out_m[6][5]), 32'd0);

      run_frame(0, 0, 0, 0);
      check_output("uniform_lit", mem[OB + 1 * W + 1], 32'h00000000);

      run_frame(1, 0, 0, 0);
      check_output("step_lit_a", mem[OB + 1 * W + 3], 32'h00FFFFFF);
      check_output("step_lit_b", mem[OB + 6 * W + 4], 32'h00FFFFFF);
      check_output("step_lit_c", mem[OB + 2 * W + 5], 32'h00000000);

      run_frame(2, 5, 0, 0);
      run_frame(2, 0, 150, 0);
      run_frame(2, 0, 0, 60);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
